// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with EX-side operand selection.
// Captures decoded ID fields, supports hold (stall) and bubble (flush),
// forwards MEM/WB results onto the ALU operands and flags load-use hazards.
module id_ex_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_shamt,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_dst,
    input  logic [4:0]  id_alu_ctl,
    input  logic        id_sign,
    input  logic        id_alu_src1,
    input  logic        id_alu_src2,
    input  logic        id_reg_write,
    input  logic        id_mem_read,
    input  logic        id_mem_write,
    input  logic [1:0]  id_mem_to_reg,
    input  logic        stall,
    input  logic        flush,
    input  logic        mem_reg_write,
    input  logic [4:0]  mem_dst,
    input  logic [31:0] mem_result,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_dst,
    input  logic [31:0] wb_result,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    output logic [4:0]  alu_ctl,
    output logic        alu_sign,
    output logic [31:0] ex_store_data,
    output logic [4:0]  ex_dst,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic [1:0]  ex_mem_to_reg,
    output logic        load_use
);

    // Registered source indices, data and operand-select fields.
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic [31:0] ex_rs_data;
    logic [31:0] ex_rt_data;
    logic [31:0] ex_imm;
    logic [4:0]  ex_shamt;
    logic        ex_src1;
    logic        ex_src2;

    // Capture-time values with the same-cycle WB write folded in.
    logic [31:0] cap_rs_data;
    logic [31:0] cap_rt_data;

    // Forwarded operand values.
    logic [31:0] fwd_rs;
    logic [31:0] fwd_rt;

    // Bypass a register-file write happening on the same edge we capture.
    always_comb begin
        cap_rs_data = id_rs_data;
        cap_rt_data = id_rt_data;
        if (wb_reg_write && (wb_dst != 5'd0) && (wb_dst == id_rs))
            cap_rs_data = wb_result;
        if (wb_reg_write && (wb_dst != 5'd0) && (wb_dst == id_rt))
            cap_rt_data = wb_result;
    end

    // Pipeline register: reset > flush (bubble) > stall (hold) > load.
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            ex_valid      <= 1'b0;
            ex_pc         <= 32'd0;
            ex_rs         <= 5'd0;
            ex_rt         <= 5'd0;
            ex_rs_data    <= 32'd0;
            ex_rt_data    <= 32'd0;
            ex_imm        <= 32'd0;
            ex_shamt      <= 5'd0;
            ex_src1       <= 1'b0;
            ex_src2       <= 1'b0;
            alu_ctl       <= 5'd0;
            alu_sign      <= 1'b0;
            ex_dst        <= 5'd0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 2'd0;
        end else if (!stall) begin
            ex_valid      <= id_valid;
            ex_pc         <= id_pc;
            ex_rs         <= id_rs;
            ex_rt         <= id_rt;
            ex_rs_data    <= cap_rs_data;
            ex_rt_data    <= cap_rt_data;
            ex_imm        <= id_imm;
            ex_shamt      <= id_shamt;
            ex_src1       <= id_alu_src1;
            ex_src2       <= id_alu_src2;
            alu_ctl       <= id_alu_ctl;
            alu_sign      <= id_sign;
            ex_dst        <= id_dst;
            ex_reg_write  <= id_reg_write;
            ex_mem_read   <= id_mem_read;
            ex_mem_write  <= id_mem_write;
            ex_mem_to_reg <= id_mem_to_reg;
        end
    end

    // Forwarding: MEM beats WB; index 0 is never forwarded.
    always_comb begin
        fwd_rs = ex_rs_data;
        fwd_rt = ex_rt_data;
        if (mem_reg_write && (mem_dst == ex_rs) && (ex_rs != 5'd0))
            fwd_rs = mem_result;
        else if (wb_reg_write && (wb_dst == ex_rs) && (ex_rs != 5'd0))
            fwd_rs = wb_result;
        if (mem_reg_write && (mem_dst == ex_rt) && (ex_rt != 5'd0))
            fwd_rt = mem_result;
        else if (wb_reg_write && (wb_dst == ex_rt) && (ex_rt != 5'd0))
            fwd_rt = wb_result;
    end

    // Operand select: shift amount or rs on in1, immediate or rt on in2.
    always_comb begin
        alu_in1       = ex_src1 ? {27'd0, ex_shamt} : fwd_rs;
        alu_in2       = ex_src2 ? ex_imm : fwd_rt;
        ex_store_data = fwd_rt;
    end

    // A load in EX whose destination is read by the instruction in ID.
    always_comb begin
        load_use = ex_valid && ex_mem_read && (ex_dst != 5'd0) && id_valid &&
                   ((ex_dst == id_rs) || (ex_dst == id_rt));
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed stimulus for id_ex_stage with a behavioural
// model checked every cycle plus hand-computed literal expectations.
module tb_id_ex_stage;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        id_valid, id_sign, id_alu_src1, id_alu_src2;
    logic        id_reg_write, id_mem_read, id_mem_write;
    logic [31:0] id_pc, id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_shamt, id_rs, id_rt, id_dst, id_alu_ctl;
    logic [1:0]  id_mem_to_reg;
    logic        stall, flush;
    logic        mem_reg_write, wb_reg_write;
    logic [4:0]  mem_dst, wb_dst;
    logic [31:0] mem_result, wb_result;

    logic        ex_valid, alu_sign, ex_reg_write, ex_mem_read, ex_mem_write, load_use;
    logic [31:0] ex_pc, alu_in1, alu_in2, ex_store_data;
    logic [4:0]  alu_ctl, ex_dst;
    logic [1:0]  ex_mem_to_reg;

    id_ex_stage dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_shamt(id_shamt), .id_rs(id_rs), .id_rt(id_rt), .id_dst(id_dst),
        .id_alu_ctl(id_alu_ctl), .id_sign(id_sign), .id_alu_src1(id_alu_src1),
        .id_alu_src2(id_alu_src2), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .stall(stall), .flush(flush),
        .mem_reg_write(mem_reg_write), .mem_dst(mem_dst), .mem_result(mem_result),
        .wb_reg_write(wb_reg_write), .wb_dst(wb_dst), .wb_result(wb_result),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .alu_ctl(alu_ctl), .alu_sign(alu_sign), .ex_store_data(ex_store_data),
        .ex_dst(ex_dst), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .load_use(load_use)
    );

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
        end
    endtask

    // Literal expectation: push the hand-computed value, pop it to compare.
    task automatic expect_lit(input string name, input logic [31:0] act, input logic [31:0] lit);
        logic [31:0] e;
        exp_q.push_back(lit);
        e = exp_q.pop_front();
        chk(name, act, e);
    endtask

    // ---------------- behavioural model ----------------
    // The instruction sitting in EX, as a record of what was captured.
    typedef struct {
        bit          valid;
        bit [31:0]   pc;
        bit [4:0]    rs, rt, dst, shamt, ctl;
        bit [31:0]   rs_val, rt_val, imm;
        bit          sign, use_shamt, use_imm, rw, mr, mw;
        bit [1:0]    m2r;
    } ex_instr_t;

    ex_instr_t m;
    bit model_live = 0;

    function automatic bit [31:0] latest_value(input bit [4:0] idx, input bit [31:0] held);
        if (idx == 0) return held;
        if (mem_reg_write && mem_dst == idx) return mem_result;
        if (wb_reg_write && wb_dst == idx) return wb_result;
        return held;
    endfunction

    always @(posedge clk) begin
        ex_instr_t n;
        if (!reset || flush) begin
            n = '{default: 0};
        end else if (stall) begin
            n = m;
        end else begin
            n.valid = id_valid;       n.pc = id_pc;
            n.rs = id_rs;             n.rt = id_rt;       n.dst = id_dst;
            n.shamt = id_shamt;       n.ctl = id_alu_ctl; n.imm = id_imm;
            n.sign = id_sign;         n.use_shamt = id_alu_src1; n.use_imm = id_alu_src2;
            n.rw = id_reg_write;      n.mr = id_mem_read; n.mw = id_mem_write;
            n.m2r = id_mem_to_reg;
            // A register written back this very edge is seen by the reader.
            n.rs_val = (wb_reg_write && wb_dst != 0 && wb_dst == id_rs) ? wb_result : id_rs_data;
            n.rt_val = (wb_reg_write && wb_dst != 0 && wb_dst == id_rt) ? wb_result : id_rt_data;
        end
        m = n;
        model_live = 1;
    end

    // Compare process: every falling edge once the model holds state.
    always @(negedge clk) begin
        if (model_live) begin
            bit [31:0] rsv, rtv;
            bit lu;
            rsv = latest_value(m.rs, m.rs_val);
            rtv = latest_value(m.rt, m.rt_val);
            lu = m.valid && m.mr && m.dst != 0 && id_valid && (m.dst == id_rs || m.dst == id_rt);
            chk("m_ex_valid", {31'd0, ex_valid}, {31'd0, m.valid});
            chk("m_ex_pc", ex_pc, m.pc);
            chk("m_alu_in1", alu_in1, m.use_shamt ? {27'd0, m.shamt} : rsv);
            chk("m_alu_in2", alu_in2, m.use_imm ? m.imm : rtv);
            chk("m_store", ex_store_data, rtv);
            chk("m_alu_ctl", {27'd0, alu_ctl}, {27'd0, m.ctl});
            chk("m_sign", {31'd0, alu_sign}, {31'd0, m.sign});
            chk("m_dst", {27'd0, ex_dst}, {27'd0, m.dst});
            chk("m_ctrl", {27'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg},
                {27'd0, m.rw, m.mr, m.mw, m.m2r});
            chk("m_load_use", {31'd0, load_use}, {31'd0, lu});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic id_clear();
        id_valid = 0; id_pc = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0;
        id_shamt = 0; id_rs = 0; id_rt = 0; id_dst = 0; id_alu_ctl = 0; id_sign = 0;
        id_alu_src1 = 0; id_alu_src2 = 0; id_reg_write = 0; id_mem_read = 0;
        id_mem_write = 0; id_mem_to_reg = 0;
    endtask

    task automatic id_random();
        id_valid = 1'($urandom); id_pc = $urandom; id_rs_data = $urandom;
        id_rt_data = $urandom; id_imm = $urandom; id_shamt = 5'($urandom);
        id_rs = 5'($urandom_range(1, 31)); id_rt = 5'($urandom_range(1, 31));
        id_dst = 5'($urandom); id_alu_ctl = 5'($urandom); id_sign = 1'($urandom);
        id_alu_src1 = 1'($urandom); id_alu_src2 = 1'($urandom);
        id_reg_write = 1; id_mem_read = 1; id_mem_write = 1; id_mem_to_reg = 2'($urandom);
    endtask

    task automatic fwd_off();
        mem_reg_write = 0; mem_dst = 0; mem_result = 0;
        wb_reg_write = 0; wb_dst = 0; wb_result = 0;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        id_clear(); fwd_off(); stall = 0; flush = 0;

        // Reset with random ID data; MEM/WB try to forward onto index 0.
        reset = 0;
        id_random();
        mem_reg_write = 1; mem_dst = 0; mem_result = 32'hCAFEF00D;
        wb_reg_write = 1; wb_dst = 0; wb_result = 32'h0BADBEEF;
        step(); id_random(); step();
        expect_lit("rst_valid", {31'd0, ex_valid}, 0);
        expect_lit("rst_pc", ex_pc, 0);
        expect_lit("rst_in1", alu_in1, 0);
        expect_lit("rst_in2", alu_in2, 0);
        expect_lit("rst_ctl", {27'd0, alu_ctl}, 0);
        expect_lit("rst_load_use", {31'd0, load_use}, 0);

        // ADD r3, r4.
        reset = 1; fwd_off(); id_clear();
        id_valid = 1; id_pc = 32'h100; id_rs = 3; id_rs_data = 5; id_rt = 4; id_rt_data = 7;
        id_alu_ctl = 5'b00010; id_dst = 6; id_reg_write = 1;
        step();
        expect_lit("add_in1", alu_in1, 5);
        expect_lit("add_in2", alu_in2, 7);
        expect_lit("add_valid", {31'd0, ex_valid}, 1);
        expect_lit("add_pc", ex_pc, 32'h100);

        // Forwarding priority on rs=8, held under stall.
        id_clear();
        id_valid = 1; id_rs = 8; id_rs_data = 32'h12345678; id_rt = 0; id_rt_data = 32'h77;
        step();
        stall = 1;
        mem_reg_write = 1; mem_dst = 8; mem_result = 32'hAAAA0000;
        wb_reg_write = 1; wb_dst = 8; wb_result = 32'h1111;
        #1 expect_lit("fwd_mem", alu_in1, 32'hAAAA0000);
        mem_reg_write = 0;
        #1 expect_lit("fwd_wb", alu_in1, 32'h1111);
        step();
        expect_lit("fwd_wb_held", alu_in1, 32'h1111);
        mem_reg_write = 1; mem_dst = 0; wb_dst = 0;
        #1 expect_lit("fwd_none", alu_in1, 32'h12345678);
        expect_lit("fwd_rt0", ex_store_data, 32'h77);
        stall = 0; fwd_off();

        // SLL by 4 of rt=1.
        id_clear();
        id_valid = 1; id_rt = 2; id_rt_data = 1; id_shamt = 4; id_alu_src1 = 1; id_alu_ctl = 5'b01000;
        step();
        expect_lit("sll_in1", alu_in1, 4);
        expect_lit("sll_in2", alu_in2, 1);

        // SW with imm 0x10, rt forwarded from MEM.
        id_clear();
        id_valid = 1; id_rs = 1; id_rs_data = 32'h2000; id_rt = 7; id_imm = 32'h10;
        id_alu_src2 = 1; id_mem_write = 1;
        step();
        mem_reg_write = 1; mem_dst = 7; mem_result = 32'hDEAD;
        #1 expect_lit("sw_in2", alu_in2, 32'h10);
        expect_lit("sw_store", ex_store_data, 32'hDEAD);
        fwd_off();

        // LW r5 then a reader of r5: stall, then flush.
        id_clear();
        id_valid = 1; id_rs = 2; id_rs_data = 32'h40; id_dst = 5; id_mem_read = 1;
        id_reg_write = 1; id_mem_to_reg = 2'd1; id_alu_src2 = 1; id_imm = 4;
        step();
        id_clear(); id_valid = 1; id_rs = 5; id_rt = 9; id_pc = 32'h204;
        #1 expect_lit("lu_hit", {31'd0, load_use}, 1);
        id_valid = 0;
        #1 expect_lit("lu_noid", {31'd0, load_use}, 0);
        id_valid = 1;
        stall = 1;
        step();
        expect_lit("stall_dst", {27'd0, ex_dst}, 5);
        expect_lit("stall_mr", {31'd0, ex_mem_read}, 1);
        expect_lit("stall_lu", {31'd0, load_use}, 1);
        stall = 0; flush = 1;
        step();
        flush = 0;
        expect_lit("flush_valid", {31'd0, ex_valid}, 0);
        expect_lit("flush_mr", {31'd0, ex_mem_read}, 0);
        expect_lit("flush_lu", {31'd0, load_use}, 0);

        // Stall and flush together: bubble wins over hold.
        id_clear(); id_valid = 1; id_pc = 32'h300; id_reg_write = 1; id_dst = 3;
        step();
        id_pc = 32'h304; id_dst = 4; stall = 1; flush = 1;
        step();
        stall = 0; flush = 0;
        expect_lit("sf_valid", {31'd0, ex_valid}, 0);
        expect_lit("sf_rw", {31'd0, ex_reg_write}, 0);
        expect_lit("sf_pc", ex_pc, 0);

        // Capture bypass of a same-edge WB write to r9.
        id_clear(); id_valid = 1; id_rs = 9; id_rs_data = 0;
        wb_reg_write = 1; wb_dst = 9; wb_result = 32'h55;
        step();
        wb_reg_write = 0;
        #1 expect_lit("bypass_rs", alu_in1, 32'h55);

        // Bypass is blocked on index 0.
        id_clear(); id_valid = 1; id_rs = 0; id_rs_data = 32'h44;
        wb_reg_write = 1; wb_dst = 0; wb_result = 32'h99;
        step();
        expect_lit("bypass_r0", alu_in1, 32'h44);
        fwd_off();

        // Reset while stalled clears everything.
        id_clear(); id_valid = 1; id_pc = 32'h400; id_dst = 2;
        step();
        stall = 1; reset = 0;
        step();
        expect_lit("rst_stall_valid", {31'd0, ex_valid}, 0);
        expect_lit("rst_stall_pc", ex_pc, 0);
        reset = 1; stall = 0;
        step(); step();

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register and EX-side operand selection for the five-stage MIPS pipeline. Captures decoded fields from ID each cycle and supports hold (stall) and bubble (flush). Drives the ALU's `in1`, `in2`, `ALUCtl` and `Sign` with MEM/WB forwarding applied. Also raises the load-use hazard signal to the hazard controller.

## Interface
Parameters: none (data width fixed at 32, register index 5).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-low reset
- `id_valid`  in  1  ID holds a real instruction
- `id_pc`  in  32  PC of the ID instruction
- `id_rs_data`, `id_rt_data`  in  32 each  register-file read data
- `id_imm`  in  32  immediate, already sign/zero-extended by decode
- `id_shamt`  in  5  shift amount field
- `id_rs`, `id_rt`, `id_dst`  in  5 each  source indices, destination index
- `id_alu_ctl`  in  5  ALU operation code
- `id_sign`  in  1  signed compare select
- `id_alu_src1`  in  1  0 = rs, 1 = shamt
- `id_alu_src2`  in  1  0 = rt, 1 = imm
- `id_reg_write`, `id_mem_read`, `id_mem_write`  in  1 each  control bits
- `id_mem_to_reg`  in  2  writeback select
- `stall`  in  1  hold current EX contents
- `flush`  in  1  insert bubble
- `mem_reg_write`  in  1  MEM-stage instruction writes a register
- `mem_dst`  in  5  MEM-stage destination index
- `mem_result`  in  32  MEM-stage result
- `wb_reg_write`  in  1  WB-stage instruction writes a register
- `wb_dst`  in  5  WB-stage destination index
- `wb_result`  in  32  WB-stage result
- `ex_valid`  out  1  EX holds a real instruction
- `ex_pc`  out  32  registered PC
- `alu_in1`, `alu_in2`  out  32 each  ALU operands
- `alu_ctl`  out  5  ALU operation code
- `alu_sign`  out  1  signed compare select
- `ex_store_data`  out  32  forwarded rt value for stores
- `ex_dst`  out  5  destination index
- `ex_reg_write`, `ex_mem_read`, `ex_mem_write`  out  1 each  control bits
- `ex_mem_to_reg`  out  2  writeback select
- `load_use`  out  1  load-use hazard detected

## Operation
- Register update priority each edge: reset low > `flush` > `stall` > load.
  - Reset low: all registered fields cleared to 0.
  - `flush`: bubble. `ex_valid`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write` go to 0; data fields are don't-care and are cleared to 0.
  - `stall` (no flush): every field holds.
  - Otherwise: all `id_*` fields are captured.
- Capture bypass: on load, if `wb_reg_write` and `wb_dst != 0` and `wb_dst == id_rs`, latch `wb_result` as the rs data. The same rule applies to rt. This covers a same-cycle register-file write.
- Forwarding (combinational from registered rs/rt indices and data; applies to both operands):
  - If `mem_reg_write` and `mem_dst == idx` and `idx != 0`: use `mem_result`.
  - Else if `wb_reg_write` and `wb_dst == idx` and `idx != 0`: use `wb_result`.
  - Else: use the registered data.
  - MEM has priority over WB.
- Operand select:
  - `alu_in1`: `{27'b0, shamt}` when src1 = 1, else forwarded rs. Shifts take the amount on in1 and the value on in2.
  - `alu_in2`: registered imm when src2 = 1, else forwarded rt.
  - `ex_store_data`: always forwarded rt, independent of src2.
- `load_use` = `ex_valid & ex_mem_read & (ex_dst != 0) & id_valid & (ex_dst == id_rs | ex_dst == id_rt)`. It is combinational and does not depend on `stall` or `flush`.
- During a held stall, forwarded operands re-evaluate every cycle against current MEM/WB values.

## Timing
- Latency: ID fields appear on EX outputs 1 cycle after capture.
- Operand outputs are combinational from registers plus MEM/WB inputs, with no added cycle.
- Reset value of every registered output is 0, including `ex_valid`, all control bits, `ex_pc`, `ex_dst` and `alu_ctl`.
  - Hence `alu_in1 = alu_in2 = 0` after reset, unless MEM/WB forward onto index 0, which is blocked.
- `stall` and `flush` high in the same cycle: flush wins.
- Reset asserted during a stall: clears regardless.
- Register index 0 is never forwarded or bypassed, even with a write enable set.

## Test plan
- Reset held low 2 cycles with random ID inputs -> all outputs 0, `load_use` = 0.
- Load ADD: rs=3 (data 5), rt=4 (data 7), `alu_ctl` = 00010, src1 = src2 = 0, no forwards -> next cycle `alu_in1` = 5, `alu_in2` = 7, `ex_valid` = 1.
- Forwarding priority: EX rs=8; `mem_dst` = 8 with `mem_result` = 0xAAAA0000 and `wb_dst` = 8 with `wb_result` = 0x1111 -> `alu_in1` = 0xAAAA0000. Drop `mem_reg_write` -> 0x1111. Set indices to 0 -> registered data.
- SLL with shamt = 4, src1 = 1, rt data 0x1 -> `alu_in1` = 0x4, `alu_in2` = 0x1. Also SW with imm = 0x10 and rt forwarded from MEM 0xDEAD -> `alu_in2` = 0x10, `ex_store_data` = 0xDEAD.
- Load-use: EX LW with dst = 5; ID `id_valid` = 1, rs = 5 -> `load_use` = 1. Apply `stall` 1 cycle -> EX unchanged. Then `flush` -> `ex_valid` = 0, `ex_mem_read` = 0, `load_use` = 0.
- `stall` and `flush` together with new ID data -> bubble, not hold.
- Capture bypass: `wb_dst` = `id_rs` = 9 with `wb_result` = 0x55 on the load edge, `id_rs_data` = 0 -> `alu_in1` = 0x55 after WB clears.
